// File: rtl/sif_wa_sink.sv
// SIF write-back sink: FWFT FIFO buffering WA writes toward a valid/ready memory port.
// Optional statistics counters are enabled by defining SIF_WA_STATS_EN.
module sif_wa_sink #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 16,
    parameter int unsigned AF_LEVEL = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AW-1:0]          wa_addr,
    input  logic [DW-1:0]          wa_data_wr,
    input  logic                   wa_wr_s,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic                   ovf,
`ifdef SIF_WA_STATS_EN
    output logic [15:0]            wr_cnt,
    output logic [15:0]            drop_cnt,
`endif
    input  logic                   ovf_clr,
    input  logic                   flush
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push_c;
    logic            pop_c;
    logic            drop_c;
    entry_t          head_c;

    // Status flags from registered level only
    always_comb begin
        empty       = (level == LW'(0));
        full        = (level == LW'(DEPTH));
        almost_full = (level >= LW'(AF_LEVEL));
    end

    // A push while full is rejected even when a pop frees space on the same edge
    always_comb begin
        push_c = wa_wr_s && !full && !flush;
        pop_c  = mem_valid && mem_ready && !flush;
        drop_c = wa_wr_s && full && !flush;
    end

    always_comb begin
        head_c    = mem[rd_ptr];
        mem_valid = !empty;
        mem_addr  = empty ? AW'(0) : head_c.addr;
        mem_data  = empty ? DW'(0) : head_c.data;
    end

    // Storage is deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (rst_n && push_c) begin
            mem[wr_ptr] <= '{addr: wa_addr, data: wa_data_wr};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + PW'(1);
                if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
                if (push_c && !pop_c) begin
                    level <= level + LW'(1);
                end else if (pop_c && !push_c) begin
                    level <= level - LW'(1);
                end
            end
            // Set wins over clear
            if (drop_c) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef SIF_WA_STATS_EN
    // Saturating counters of accepted and rejected pushes
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_cnt   <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_c && wr_cnt != 16'hFFFF)   wr_cnt   <= wr_cnt + 16'd1;
            if (drop_c && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/sif_wa_sink.md
Name: sif_wa_sink

Overview:
Downstream consumer of the SIF write-back (WA) port. Captures every WA write strobe (address plus data) into a small first-word-fall-through FIFO and drains the entries to a memory/register-bank port over a valid/ready handshake. Decouples the SIF core, which has no back-pressure on WA, from a slower target. Reports fill level, sticky overflow, and almost-full status.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
AW, 16, address width; matches wa_addr.
DW, 16, data width; matches wa_data_wr.
AF_LEVEL, 6, almost_full asserts when level >= AF_LEVEL; must be 1..DEPTH.

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  synchronous active-low reset.
wa_addr  input  AW  write address from the SIF core.
wa_data_wr  input  DW  write data from the SIF core.
wa_wr_s  input  1  write strobe; one write per cycle while high.
mem_valid  output  1  head entry is presented on mem_addr/mem_data.
mem_ready  input  1  target accepts the head entry.
mem_addr  output  AW  head entry address.
mem_data  output  DW  head entry data.
level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
empty  output  1  level == 0.
full  output  1  level == DEPTH.
almost_full  output  1  level >= AF_LEVEL.
ovf  output  1  sticky: a write was dropped.
ovf_clr  input  1  clears ovf.
flush  input  1  discards all entries.

Behaviour:
- Reset (rst_n low at a posedge):
  - rd/wr pointers = 0; level = 0; empty = 1; full = 0; almost_full = 0; ovf = 0; mem_valid = 0.
  - mem_addr and mem_data = 0.
  - Storage array is not cleared.
- Push: wa_wr_s = 1 and full = 0 at a posedge -> {wa_addr, wa_data_wr} is written at wr_ptr, and wr_ptr increments.
- Pop: mem_valid = 1 and mem_ready = 1 at a posedge -> rd_ptr increments.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- level update each cycle: +1 push only; -1 pop only; unchanged if both or neither.
- Full boundary: full is evaluated on registered state before the edge. A push while full is rejected even if a pop occurs in the same cycle.
  - The rejected write is dropped and ovf sets to 1 on that edge.
  - The pop still completes, so level becomes DEPTH-1.
- Empty boundary: push into an empty FIFO -> mem_valid = 1 the next cycle, with the entry on mem_addr/mem_data. Latency from wa_wr_s to mem_valid is 1 cycle; no same-cycle bypass.
- FWFT outputs: mem_addr/mem_data are a combinational read of storage at rd_ptr, gated to 0 when empty. mem_valid = !empty.
- Handshake: mem_addr/mem_data stay stable while mem_valid = 1 and mem_ready = 0. mem_ready while empty has no effect.
- Status flags: empty, full, and almost_full are derived combinationally from registered level.
- ovf_clr: clears ovf on the next edge. If a drop occurs in the same cycle as ovf_clr, set wins and ovf = 1.
- flush: on the next edge, pointers and level go to 0, with priority over push and pop in the same cycle. A concurrent wa_wr_s is discarded and does not set ovf. ovf is unaffected by flush.
- Reset mid-operation: all in-flight entries are lost. mem_valid drops on the reset edge, and rst_n has priority over flush and ovf_clr.
- Ordering: strictly in order; no reordering or merging.

Optional Feature:
Macro SIF_WA_STATS_EN.
- Defined:
  - Adds outputs wr_cnt[15:0] (accepted pushes) and drop_cnt[15:0] (rejected pushes).
  - Both reset to 0 and saturate at 16'hFFFF.
  - Both clear on flush; a push in the flush cycle is not counted.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then one write addr=16'h0010 data=16'hA5A5 with mem_ready=0 -> next cycle mem_valid=1, mem_addr=16'h0010, mem_data=16'hA5A5, level=1; held stable for 5 cycles.
2. 8 back-to-back writes addr=0..7 (data=addr+16'h100) with mem_ready=0 -> full=1, level=8, almost_full=1 from level 6. Then mem_ready=1 -> 8 pops in order, data 16'h100..16'h107, then empty=1.
3. Full FIFO, a 9th write with mem_ready=1 in the same cycle -> write dropped, ovf=1, level=7; head order unchanged. ovf_clr pulse -> ovf=0.
4. Continuous write and pop with mem_ready=1 for 20 writes -> level stays at 1; pointer wrap is exercised; all 20 data words arrive in order.
5. level=5 when flush and wa_wr_s are asserted together -> next cycle level=0, empty=1, mem_valid=0, ovf unchanged. With SIF_WA_STATS_EN: wr_cnt=0.
6. Assert rst_n=0 for one cycle with level=3 and ovf=1 -> all outputs at reset values next cycle. A following write appears as the sole entry.
